ble_chan_hop_scheduler: RTL and testbench



---
 rtl/ble_chan_hop_scheduler_pkg.sv | 48 ++++
 rtl/ble_chan_hop_scheduler_if.sv | 28 ++
 rtl/ble_chan_hop_scheduler_remap.sv | 98 +++++++++
 rtl/ble_chan_hop_scheduler.sv | 155 +++++++++++++++
 tb/tb_ble_chan_hop_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ble_chan_hop_scheduler_pkg.sv
// Shared types and constants for the BLE channel hop scheduler.
//   NUM_DATA_CH / ADV_CH_BASE / NUM_CH : channel fabric geometry
//   chan_idx_t                          : internal 6-bit channel index
//   sched_state_e                       : scheduler / remap engine states
//   popcount_map, adv_select            : helpers used by the top
package ble_chan_pkg;

  localparam int unsigned NUM_DATA_CH = 37;
  localparam int unsigned ADV_CH_BASE = 37;
  localparam int unsigned NUM_CH      = 40;

  typedef logic [5:0] chan_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADV,
    ST_CALC,
    ST_CHECK,
    ST_MOD,
    ST_SCAN,
    ST_DONE
  } sched_state_e;

  function automatic chan_idx_t popcount_map(input logic [NUM_DATA_CH-1:0] m);
    chan_idx_t n;
    n = '0;
    for (int unsigned i = 0; i < NUM_DATA_CH; i++) begin
      n = n + chan_idx_t'(m[i]);
    end
    return n;
  endfunction

  // Returns {found, position}: first enabled advertising channel at or after
  // ptr, searching circularly over the three positions (0=ch37 .. 2=ch39).
  function automatic logic [2:0] adv_select(input logic [2:0] en, input logic [1:0] ptr);
    logic [2:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      idx = (32'(ptr) + k) % 3;
      if (!res[2] && en[2'(idx)]) begin
        res = {1'b1, 2'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ble_chan_hop_scheduler_if.sv
// Endpoint <-> scheduler signal bundle.
//   master : endpoint side, drives configuration and event requests
//   slave  : scheduler side, returns chan_valid/channel_index/busy/map_err
interface ble_chan_hop_scheduler_if #(
  parameter int unsigned CH_IDX_W = 32,
  parameter int unsigned NUM_DATA = 37
);
  logic                mode_adv;
  logic                start_conn;
  logic [4:0]          hop_incr;
  logic [NUM_DATA-1:0] chan_map;
  logic [2:0]          adv_chan_map;
  logic                evt_req;
  logic                chan_valid;
  logic [CH_IDX_W-1:0] channel_index;
  logic                busy;
  logic                map_err;

  modport master (
    output mode_adv, start_conn, hop_incr, chan_map, adv_chan_map, evt_req,
    input  chan_valid, channel_index, busy, map_err
  );

  modport slave (
    input  mode_adv, start_conn, hop_incr, chan_map, adv_chan_map, evt_req,
    output chan_valid, channel_index, busy, map_err
  );
endinterface

// File: rtl/ble_chan_hop_scheduler_remap.sv
// CSA#1 remap engine: reduces the unmapped channel modulo num_used by
// repeated subtraction, then walks the used-map to find the rem-th used
// channel.
//   clk, rst_n   : clock, async active-low reset
//   start_i      : load unmapped_i and begin the reduction
//   abort_i      : drop any computation in progress
//   unmapped_i   : unmapped channel (0..36)
//   map_i        : data channel used-map
//   num_used_i   : popcount of map_i (>= 2 whenever start_i is raised)
//   done_o       : 1-cycle pulse, remapped_o valid
//   remapped_o   : remapped data channel
module ble_chan_remap
  import ble_chan_pkg::*;
#(
  parameter int unsigned NUM_DATA = NUM_DATA_CH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  chan_idx_t           unmapped_i,
  input  logic [NUM_DATA-1:0] map_i,
  input  chan_idx_t           num_used_i,
  output logic                done_o,
  output chan_idx_t           remapped_o
);

  localparam chan_idx_t LAST_PTR = chan_idx_t'(NUM_DATA - 1);

  sched_state_e state_q, state_d;
  chan_idx_t    rem_q, rem_d;
  chan_idx_t    ptr_q, ptr_d;
  chan_idx_t    cnt_q, cnt_d;
  logic         hit;
  logic         scan_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d   = unmapped_i;
          state_d = ST_MOD;
        end
      end
      ST_MOD: begin
        if (rem_q >= num_used_i) begin
          rem_d = rem_q - num_used_i;
        end else begin
          state_d = ST_SCAN;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        if (scan_end) begin
          state_d = ST_IDLE;
        end else begin
          if (map_i[ptr_q]) begin
            cnt_d = cnt_q + chan_idx_t'(1);
          end
          ptr_d = ptr_q + chan_idx_t'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
    end
  end

  // The last-pointer term only guards against a map that changed under us;
  // with rem < num_used a hit always occurs first.
  always_comb begin
    hit        = map_i[ptr_q] && (cnt_q == rem_q);
    scan_end   = (state_q == ST_SCAN) && (hit || (ptr_q == LAST_PTR));
    done_o     = scan_end;
    remapped_o = ptr_q;
  end

endmodule

// File: rtl/ble_chan_hop_scheduler.sv
// Per-endpoint BLE channel selector.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of ble_chan_hop_scheduler_if
//                (mode_adv, start_conn, hop_incr, chan_map, adv_chan_map,
//                 evt_req in; chan_valid, channel_index, busy, map_err out)
// Advertising events rotate over the enabled channels 37..39; connection
// events run Channel Selection Algorithm #1 with the remap delegated to
// ble_chan_remap.
module ble_chan_hop_scheduler
  import ble_chan_pkg::*;
#(
  parameter int unsigned CH_IDX_W = 32,
  parameter int unsigned NUM_DATA = NUM_DATA_CH
) (
  input logic                     clk,
  input logic                     rst_n,
  ble_chan_hop_scheduler_if.slave bus
);

  sched_state_e        state_q, state_d;
  chan_idx_t           last_unm_q, last_unm_d;
  chan_idx_t           unm_q, unm_d;
  logic [1:0]          adv_ptr_q, adv_ptr_d;
  chan_idx_t           chan_q, chan_d;
  logic                map_err_q, map_err_d;

  // Connection configuration survives reset; only start_conn loads it.
  logic [4:0]          hop_q;
  logic [NUM_DATA-1:0] map_q;
  chan_idx_t           num_used_q;

  logic                cfg_err;
  logic [2:0]          adv_sel;
  chan_idx_t           sum_c;
  chan_idx_t           unm_c;
  logic                remap_start;
  logic                remap_done;
  chan_idx_t           remapped;

  always_ff @(posedge clk) begin
    if (bus.start_conn) begin
      hop_q <= bus.hop_incr;
      map_q <= bus.chan_map;
    end
    num_used_q <= popcount_map(map_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_unm_q <= '0;
      unm_q      <= '0;
      adv_ptr_q  <= '0;
      chan_q     <= '0;
      map_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_unm_q <= last_unm_d;
      unm_q      <= unm_d;
      adv_ptr_q  <= adv_ptr_d;
      chan_q     <= chan_d;
      map_err_q  <= map_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_unm_d  = last_unm_q;
    unm_d       = unm_q;
    adv_ptr_d   = adv_ptr_q;
    chan_d      = chan_q;
    map_err_d   = 1'b0;
    remap_start = 1'b0;

    cfg_err = (num_used_q < chan_idx_t'(2)) || (hop_q < 5'd5) || (hop_q > 5'd16);
    adv_sel = adv_select(bus.adv_chan_map, adv_ptr_q);
    sum_c   = last_unm_q + chan_idx_t'(hop_q);
    unm_c   = (sum_c >= chan_idx_t'(NUM_DATA_CH)) ? sum_c - chan_idx_t'(NUM_DATA_CH) : sum_c;

    if (bus.start_conn) begin
      // Abort wins over everything, including an evt_req in the same cycle.
      state_d    = ST_IDLE;
      last_unm_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.evt_req) begin
            if (bus.mode_adv) begin
              state_d = ST_ADV;
            end else if (cfg_err) begin
              map_err_d = 1'b1;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_ADV: begin
          if (!adv_sel[2]) begin
            map_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            chan_d    = chan_idx_t'(ADV_CH_BASE) + chan_idx_t'(adv_sel[1:0]);
            adv_ptr_d = (adv_sel[1:0] == 2'd2) ? 2'd0 : adv_sel[1:0] + 2'd1;
            state_d   = ST_DONE;
          end
        end
        ST_CALC: begin
          unm_d      = unm_c;
          last_unm_d = unm_c;
          state_d    = ST_CHECK;
        end
        ST_CHECK: begin
          if (map_q[unm_q]) begin
            chan_d  = unm_q;
            state_d = ST_DONE;
          end else begin
            remap_start = 1'b1;
            state_d     = ST_MOD;
          end
        end
        // ST_MOD spans the whole remap; the engine tracks MOD/SCAN itself.
        ST_MOD: begin
          if (remap_done) begin
            chan_d  = remapped;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.chan_valid    = (state_q == ST_DONE);
    bus.busy          = (state_q != ST_IDLE);
    bus.map_err       = map_err_q;
    bus.channel_index = CH_IDX_W'(chan_q);
  end

  ble_chan_remap #(
    .NUM_DATA (NUM_DATA)
  ) u_remap (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (remap_start),
    .abort_i    (bus.start_conn),
    .unmapped_i (unm_q),
    .map_i      (map_q),
    .num_used_i (num_used_q),
    .done_o     (remap_done),
    .remapped_o (remapped)
  );

endmodule

// File: tb/tb_ble_chan_hop_scheduler.sv
module tb_ble_chan_hop_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  int          m_last;
  int          m_hop;
  int          m_adv_ptr;
  logic [36:0] m_map;

  always #5 clk = ~clk;

  ble_chan_hop_scheduler_if #(.CH_IDX_W(32), .NUM_DATA(37)) bus ();

  ble_chan_hop_scheduler #(.CH_IDX_W(32), .NUM_DATA(37)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int popc(input logic [36:0] m);
    int n = 0;
    for (int i = 0; i < 37; i++) n += int'(m[i]);
    return n;
  endfunction

  function automatic int nth_set(input logic [36:0] m, input int n);
    int seen = 0;
    for (int i = 0; i < 37; i++) begin
      if (m[i]) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  // CSA#1 from its definition: unmapped = (last + hop) mod 37; if unused,
  // take the (unmapped mod num_used)-th used channel. Latency follows from
  // the documented event timeline.
  task automatic model_data(output int ch, output int lat, output logic err);
    int nu, unm, rem;
    nu  = popc(m_map);
    err = 1'b0;
    ch  = 0;
    lat = 1;
    if (nu < 2 || m_hop < 5 || m_hop > 16) begin
      err = 1'b1;
      return;
    end
    unm    = (m_last + m_hop) % 37;
    m_last = unm;
    if (m_map[unm]) begin
      ch  = unm;
      lat = 3;
    end else begin
      rem = unm % nu;
      ch  = nth_set(m_map, rem);
      lat = 3 + (unm / nu + 1) + ch + 1;
    end
  endtask

  task automatic model_adv(input logic [2:0] en, output int ch, output logic err);
    int idx;
    err = 1'b0;
    ch  = 0;
    if (en == 3'b000) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < 3; k++) begin
      idx = (m_adv_ptr + k) % 3;
      if (en[idx]) break;
    end
    ch        = 37 + idx;
    m_adv_ptr = (idx + 1) % 3;
  endtask

  task automatic cfg(input int hop, input logic [36:0] map);
    bus.hop_incr   = 5'(hop);
    bus.chan_map   = map;
    bus.start_conn = 1'b1;
    tick;
    bus.start_conn = 1'b0;
    tick;
    tick;
    m_hop  = hop % 32;
    m_map  = map;
    m_last = 0;
  endtask

  // Issues one event and waits (bounded) for chan_valid or map_err.
  task automatic do_event(input logic adv, output int lat, output logic v,
                          output logic e, output int ch);
    bus.mode_adv = adv;
    bus.evt_req  = 1'b1;
    tick;
    bus.evt_req = 1'b0;
    lat = 1;
    v   = 1'b0;
    e   = 1'b0;
    while (lat < 100) begin
      if (bus.chan_valid) begin v = 1'b1; break; end
      if (bus.map_err)    begin e = 1'b1; break; end
      tick;
      lat++;
    end
    ch = int'(bus.channel_index);
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.mode_adv = 1'b0; bus.start_conn = 1'b0; bus.hop_incr = '0;
    bus.chan_map = '0; bus.adv_chan_map = '0; bus.evt_req = 1'b0;
    tick;
    tick;
    tests++; if (bus.chan_valid !== 1'b0) begin fails++; $display("FAIL reset_chan_valid: got %0b expected 0", bus.chan_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    tests++; if (bus.map_err !== 1'b0) begin fails++; $display("FAIL reset_map_err: got %0b expected 0", bus.map_err); end
    tests++; if (bus.channel_index !== 32'd0) begin fails++; $display("FAIL reset_channel_index: got %0d expected 0", bus.channel_index); end
    rst_n = 1'b1;
    tick;
    m_last = 0; m_adv_ptr = 0; m_hop = 0; m_map = '0;
  endtask

  task automatic test_adv;
    int lat, ch, ech, hold; logic v, e, eerr;
    bus.adv_chan_map = 3'b101;
    for (int i = 0; i < 3; i++) begin
      model_adv(3'b101, ech, eerr);
      do_event(1'b1, lat, v, e, ch);
      tests++; if (!v || ch != ech) begin fails++; $display("FAIL adv_channel[%0d]: got valid=%0b ch=%0d expected ch=%0d", i, v, ch, ech); end
      tests++; if (lat != 2) begin fails++; $display("FAIL adv_latency[%0d]: got %0d expected 2", i, lat); end
    end
    hold = ch;
    bus.adv_chan_map = 3'b000;
    do_event(1'b1, lat, v, e, ch);
    tests++; if (!e || v || lat != 2) begin fails++; $display("FAIL adv_empty_err: got err=%0b valid=%0b lat=%0d expected err=1 valid=0 lat=2", e, v, lat); end
    tests++; if (ch != hold) begin fails++; $display("FAIL adv_empty_hold: got %0d expected %0d", ch, hold); end
  endtask

  task automatic test_small_map;
    int lat, ch, ech, elat; logic v, e, eerr;
    cfg(5, 37'h3FF);
    for (int i = 0; i < 3; i++) begin
      model_data(ech, elat, eerr);
      do_event(1'b0, lat, v, e, ch);
      tests++; if (!v || ch != ech) begin fails++; $display("FAIL small_map_channel[%0d]: got valid=%0b ch=%0d expected ch=%0d", i, v, ch, ech); end
      tests++; if (lat != elat) begin fails++; $display("FAIL small_map_latency[%0d]: got %0d expected %0d", i, lat, elat); end
    end
  endtask

  task automatic test_wrap;
    int lat, ch, ech, elat; logic v, e, eerr;
    cfg(5, {37{1'b1}});
    for (int i = 0; i < 15; i++) begin
      model_data(ech, elat, eerr);
      do_event(1'b0, lat, v, e, ch);
      tests++; if (!v || ch != ech || lat != elat) begin fails++; $display("FAIL wrap[%0d]: got valid=%0b ch=%0d lat=%0d expected ch=%0d lat=%0d", i, v, ch, lat, ech, elat); end
    end
  endtask

  task automatic test_errors;
    int lat, ch; logic v, e;
    int          hops [3] = '{5, 4, 17};
    logic [36:0] maps [3];
    maps[0] = 37'd1 << $urandom_range(0, 36);
    maps[1] = {37{1'b1}};
    maps[2] = {37{1'b1}};
    for (int i = 0; i < 3; i++) begin
      cfg(hops[i], maps[i]);
      do_event(1'b0, lat, v, e, ch);
      tests++; if (!e || v || lat != 1) begin fails++; $display("FAIL cfg_err[%0d]: got err=%0b valid=%0b lat=%0d expected err=1 valid=0 lat=1", i, e, v, lat); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL cfg_err_busy[%0d]: got %0b expected 0", i, bus.busy); end
    end
  endtask

  task automatic test_abort;
    int lat, ch, ech, elat, seen; logic v, e, eerr;
    logic [36:0] map;
    map = '0;
    for (int i = 20; i < 37; i++) map[i] = 1'b1;
    cfg(5, map);
    bus.mode_adv = 1'b0;
    bus.evt_req  = 1'b1;
    tick;
    bus.evt_req = 1'b0;
    repeat (8) tick;
    bus.start_conn = 1'b1;
    bus.evt_req    = 1'b1;
    tick;
    bus.start_conn = 1'b0;
    bus.evt_req    = 1'b0;
    m_last = 0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %0b expected 0", bus.busy); end
    seen = 0;
    repeat (40) begin
      if (bus.chan_valid || bus.busy) seen++;
      tick;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen); end
    // Second evt_req lands while busy and must be dropped.
    model_data(ech, elat, eerr);
    bus.evt_req = 1'b1;
    tick;
    bus.evt_req = 1'b0;
    tick;
    bus.evt_req = 1'b1;
    tick;
    bus.evt_req = 1'b0;
    lat = 3;
    while (lat < 100 && !bus.chan_valid) begin tick; lat++; end
    ch = int'(bus.channel_index);
    tests++; if (!bus.chan_valid || ch != ech || lat != elat) begin fails++; $display("FAIL abort_restart: got valid=%0b ch=%0d lat=%0d expected ch=%0d lat=%0d", bus.chan_valid, ch, lat, ech, elat); end
    tick;
    seen = 0;
    repeat (40) begin
      if (bus.chan_valid) seen++;
      tick;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL busy_evt_dropped: got %0d extra chan_valid expected 0", seen); end
    model_data(ech, elat, eerr);
    do_event(1'b0, lat, v, e, ch);
    tests++; if (!v || ch != ech || lat != elat) begin fails++; $display("FAIL abort_next: got valid=%0b ch=%0d lat=%0d expected ch=%0d lat=%0d", v, ch, lat, ech, elat); end
  endtask

  task automatic test_reset_mid_scan;
    int lat, ch, ech, elat; logic v, e, eerr;
    logic [36:0] map;
    map = '0;
    for (int i = 30; i < 37; i++) map[i] = 1'b1;
    cfg(5, map);
    bus.mode_adv = 1'b0;
    bus.evt_req  = 1'b1;
    tick;
    bus.evt_req = 1'b0;
    repeat (10) tick;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_scan_busy: got %0b expected 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.chan_valid !== 1'b0 || bus.map_err !== 1'b0 || bus.channel_index !== 32'd0) begin
      fails++; $display("FAIL async_reset_outputs: got busy=%0b valid=%0b err=%0b ch=%0d expected all 0", bus.busy, bus.chan_valid, bus.map_err, bus.channel_index);
    end
    tick;
    rst_n = 1'b1;
    tick;
    m_last = 0;
    m_adv_ptr = 0;
    model_data(ech, elat, eerr);
    do_event(1'b0, lat, v, e, ch);
    tests++; if (!v || ch != ech || lat != elat) begin fails++; $display("FAIL post_reset_event: got valid=%0b ch=%0d lat=%0d expected ch=%0d lat=%0d", v, ch, lat, ech, elat); end
  endtask

  task automatic test_random;
    int lat, ch, ech, elat, sel; logic v, e, eerr, adv;
    logic [36:0] map;
    int hop;
    for (int i = 0; i < 60; i++) begin
      if (i == 0 || $urandom_range(0, 5) == 0) begin
        hop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(5, 16));
        sel = $urandom_range(0, 3);
        map = 37'({$urandom, $urandom});
        if (sel == 1) map = map & 37'({$urandom, $urandom}) & 37'({$urandom, $urandom});
        if (sel == 2) map = ($urandom_range(0, 1) == 0) ? 37'd0 : (37'd1 << $urandom_range(0, 36));
        if (sel == 3) map = (37'd1 << $urandom_range(0, 36)) | (37'd1 << $urandom_range(0, 36));
        cfg(hop, map);
      end
      adv = ($urandom_range(0, 2) == 0);
      if (adv) begin
        bus.adv_chan_map = 3'($urandom_range(0, 7));
        model_adv(bus.adv_chan_map, ech, eerr);
        elat = 2;
      end else begin
        model_data(ech, elat, eerr);
      end
      do_event(adv, lat, v, e, ch);
      if (eerr) begin
        tests++; if (!e || v || lat != elat) begin fails++; $display("FAIL rand_err[%0d] adv=%0b: got err=%0b valid=%0b lat=%0d expected err=1 lat=%0d", i, adv, e, v, lat, elat); end
      end else begin
        tests++; if (!v || ch != ech || lat != elat) begin fails++; $display("FAIL rand_event[%0d] adv=%0b: got valid=%0b ch=%0d lat=%0d expected ch=%0d lat=%0d", i, adv, v, ch, lat, ech, elat); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_adv;
    test_small_map;
    test_wrap;
    test_errors;
    test_abort;
    test_reset_mid_scan;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
